// File: rtl/axi_vdm_write_master_if.sv
// axi_vdm_write_master_if: AXI4 write-only bus (AW, W, B) between the VDM write master and the interconnect.
interface axi_vdm_write_master_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 7
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_vdm_write_master.sv
// axi_vdm_write_master: turns VDM fragment commands (header + payload) into AXI4 write bursts, header in low 128 bits of beat 0.
// Define AXI_VDM_WR_TIMEOUT_EN to add a B-response timeout (parameter TMO_CYC, output o_tmo).
module axi_vdm_write_master #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 7,
  parameter int MAX_OUTST = 4,
  parameter int ERR_CNT_W = 16
`ifdef AXI_VDM_WR_TIMEOUT_EN
  , parameter int TMO_CYC = 1024
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [7:0]            i_cmd_len,
  input  logic [127:0]          i_cmd_header,
  input  logic                  i_pl_valid,
  output logic                  o_pl_ready,
  input  logic [DATA_W-1:0]     i_pl_data,
  input  logic                  i_pl_last,
  axi_vdm_write_master_if.master m_axi,
  output logic [3:0]            o_outst,
  output logic [ERR_CNT_W-1:0]  o_bresp_err_cnt,
  output logic [ERR_CNT_W-1:0]  o_len_err_cnt,
  output logic                  o_busy
`ifdef AXI_VDM_WR_TIMEOUT_EN
  , output logic                o_tmo
`endif
);
  typedef enum logic [1:0] {IDLE, AW, W} state_t;
  localparam logic [DATA_W-1:0] LO_MASK  = DATA_W'({128{1'b1}});
  localparam logic [2:0]        AXI_SIZE = 3'($clog2(DATA_W/8));
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [127:0]          hdr_q, hdr_d;
  logic                  awvalid_q, awvalid_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  wlast_q, wlast_d;
  logic                  wvalid_q, wvalid_d;
  logic [8:0]            beat_q, beat_d;
  logic [3:0]            outst_q, outst_d;
  logic [ERR_CNT_W-1:0]  berr_q, berr_d;
  logic [ERR_CNT_W-1:0]  lerr_q, lerr_d;
  logic                  bready_q, bready_d;
  logic                  cmd_hs, aw_hs, w_hs, b_hs, pl_hs, last_beat, b_real, berr_inc, lerr_inc, tmo_fire;
`ifdef AXI_VDM_WR_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;
  assign o_tmo = tmo_q;
`endif
  assign o_cmd_ready     = state_q == IDLE && outst_q < 4'(MAX_OUTST);
  assign o_pl_ready      = state_q == W && beat_q <= {1'b0, len_q} && (!wvalid_q || m_axi.wready);
  assign o_outst         = outst_q;
  assign o_bresp_err_cnt = berr_q;
  assign o_len_err_cnt   = lerr_q;
  assign o_busy          = state_q != IDLE || outst_q != 4'd0;
  assign m_axi.awid      = id_q;
  assign m_axi.awaddr    = addr_q;
  assign m_axi.awlen     = len_q;
  assign m_axi.awsize    = AXI_SIZE;
  assign m_axi.awburst   = 2'b01;
  assign m_axi.awvalid   = awvalid_q;
  assign m_axi.wdata     = wdata_q;
  assign m_axi.wstrb     = '1;
  assign m_axi.wlast     = wlast_q;
  assign m_axi.wvalid    = wvalid_q;
  assign m_axi.bready    = bready_q;
  always_comb begin
    cmd_hs    = i_cmd_valid && o_cmd_ready;
    aw_hs     = awvalid_q && m_axi.awready;
    w_hs      = wvalid_q && m_axi.wready;
    b_hs      = m_axi.bvalid && bready_q;
    pl_hs     = i_pl_valid && o_pl_ready;
    last_beat = beat_q == {1'b0, len_q};
    b_real    = b_hs && outst_q != 4'd0;
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    hdr_d     = hdr_q;
    awvalid_d = awvalid_q;
    id_d      = id_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    wvalid_d  = wvalid_q;
    beat_d    = beat_q;
    bready_d  = 1'b1;
    case (state_q)
      IDLE: if (cmd_hs) begin
        addr_d    = i_cmd_addr;
        len_d     = i_cmd_len;
        hdr_d     = i_cmd_header;
        awvalid_d = 1'b1;
        state_d   = AW;
      end
      AW: if (aw_hs) begin
        awvalid_d = 1'b0;
        id_d      = id_q + 1'b1;
        beat_d    = '0;
        state_d   = W;
      end
      W: begin
        if (w_hs) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (pl_hs) begin
          wvalid_d = 1'b1;
          wlast_d  = last_beat;
          wdata_d  = beat_q == 9'd0 ? (i_pl_data & ~LO_MASK) | DATA_W'(hdr_q) : i_pl_data;
          beat_d   = beat_q + 1'b1;
        end
        if (w_hs && wlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // AW and B in the same cycle cancel; a B with nothing outstanding is spurious and only counted
    outst_d = outst_q + {3'b0, aw_hs} - {3'b0, b_real};
`ifdef AXI_VDM_WR_TIMEOUT_EN
    tmo_fire  = outst_q != 4'd0 && !b_hs && tmo_cnt_q == TW'(TMO_CYC - 1);
    tmo_cnt_d = (b_hs || outst_q == 4'd0 || tmo_fire) ? '0 : tmo_cnt_q + 1'b1;
    tmo_d     = tmo_fire;
    if (tmo_fire) outst_d = '0;
`else
    tmo_fire  = 1'b0;
`endif
    berr_inc = (b_hs && (m_axi.bresp != 2'b00 || outst_q == 4'd0)) || tmo_fire;
    lerr_inc = pl_hs && (i_pl_last != last_beat);
    berr_d   = (berr_inc && !(&berr_q)) ? berr_q + 1'b1 : berr_q;
    lerr_d   = (lerr_inc && !(&lerr_q)) ? lerr_q + 1'b1 : lerr_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      awvalid_q <= 1'b0;
      id_q      <= '0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      beat_q    <= '0;
      outst_q   <= '0;
      berr_q    <= '0;
      lerr_q    <= '0;
      bready_q  <= 1'b0;
`ifdef AXI_VDM_WR_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      hdr_q     <= hdr_d;
      awvalid_q <= awvalid_d;
      id_q      <= id_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      wvalid_q  <= wvalid_d;
      beat_q    <= beat_d;
      outst_q   <= outst_d;
      berr_q    <= berr_d;
      lerr_q    <= lerr_d;
      bready_q  <= bready_d;
`ifdef AXI_VDM_WR_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_vdm_write_master.sv
// tb_axi_vdm_write_master: directed scenario tasks against hand-computed expectations for the VDM AXI write master.
module tb_axi_vdm_write_master;
  localparam int DW = 256, AW = 64, IW = 7;
  logic i_clk = 1'b0, i_reset_n = 1'b0;
  logic i_cmd_valid = 1'b0, o_cmd_ready;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [7:0] i_cmd_len = '0;
  logic [127:0] i_cmd_header = '0;
  logic i_pl_valid = 1'b0, o_pl_ready, i_pl_last = 1'b0;
  logic [DW-1:0] i_pl_data = '0;
  logic [3:0] o_outst;
  logic [15:0] o_bresp_err_cnt, o_len_err_cnt;
  logic o_busy;
  int checks = 0, failures = 0;
  int aw_cnt, w_cnt, stab_viol, outst_peak;
  logic [IW-1:0] aw_ids[$];
  logic [AW-1:0] aw_addrs[$];
  logic [7:0] aw_lens[$];
  logic [DW-1:0] w_data[$];
  logic w_lasts[$];
  logic pend_aw = 1'b0, pend_w = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;
  logic done;
  always #5 i_clk = ~i_clk;
  axi_vdm_write_master_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) m_axi();
  axi_vdm_write_master #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MAX_OUTST(4), .ERR_CNT_W(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .i_cmd_header(i_cmd_header),
    .i_pl_valid(i_pl_valid), .o_pl_ready(o_pl_ready), .i_pl_data(i_pl_data), .i_pl_last(i_pl_last),
    .m_axi(m_axi), .o_outst(o_outst), .o_bresp_err_cnt(o_bresp_err_cnt),
    .o_len_err_cnt(o_len_err_cnt), .o_busy(o_busy));
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      pend_aw = 1'b0;
      pend_w = 1'b0;
    end else begin
      if (pend_aw && (!m_axi.awvalid || m_axi.awaddr !== prev_awaddr)) stab_viol++;
      if (pend_w && (!m_axi.wvalid || m_axi.wdata !== prev_wdata)) stab_viol++;
      pend_aw = m_axi.awvalid && !m_axi.awready;
      pend_w = m_axi.wvalid && !m_axi.wready;
      prev_awaddr = m_axi.awaddr;
      prev_wdata = m_axi.wdata;
      if (m_axi.awvalid && m_axi.awready) begin
        aw_cnt++;
        aw_ids.push_back(m_axi.awid);
        aw_addrs.push_back(m_axi.awaddr);
        aw_lens.push_back(m_axi.awlen);
      end
      if (m_axi.wvalid && m_axi.wready) begin
        w_cnt++;
        w_data.push_back(m_axi.wdata);
        w_lasts.push_back(m_axi.wlast);
      end
      if (int'(o_outst) > outst_peak) outst_peak = int'(o_outst);
    end
  end
  function automatic logic [DW-1:0] beat(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction
  function automatic logic [7:0] bbyte(input logic [7:0] seed, input int k);
    return seed + 8'(k * 17);
  endfunction
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic clear_mon();
    aw_cnt = 0; w_cnt = 0; stab_viol = 0; outst_peak = 0;
    aw_ids.delete(); aw_addrs.delete(); aw_lens.delete(); w_data.delete(); w_lasts.delete();
  endtask
  task automatic do_reset();
    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_pl_valid = 1'b0; i_pl_last = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00; m_axi.bid = '0; m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    repeat (2) step();
    i_reset_n = 1'b1;
    clear_mon();
  endtask
  task automatic send_cmd(input logic [AW-1:0] addr, input logic [7:0] len, input logic [127:0] hdr);
    int n = 0;
    step();
    i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_len = len; i_cmd_header = hdr;
    @(negedge i_clk);
    while (!o_cmd_ready && n < 200) begin @(negedge i_clk); n++; end
    if (n >= 200) begin checks++; failures++; $display("FAIL cmd_accept_timeout addr=%h", addr); end
    step();
    i_cmd_valid = 1'b0;
  endtask
  task automatic send_payload(input int len, input logic [15:0] last_mask, input logic [7:0] seed);
    for (int k = 0; k <= len; k++) begin
      int n = 0;
      step();
      i_pl_valid = 1'b1; i_pl_data = beat(bbyte(seed, k)); i_pl_last = last_mask[k];
      @(negedge i_clk);
      while (!o_pl_ready && n < 200) begin @(negedge i_clk); n++; end
      if (n >= 200) begin checks++; failures++; $display("FAIL pl_accept_timeout beat=%0d", k); end
    end
    step();
    i_pl_valid = 1'b0; i_pl_last = 1'b0;
  endtask
  task automatic wait_w(input int target);
    int n = 0;
    while (w_cnt < target && n < 500) begin @(negedge i_clk); n++; end
    if (n >= 500) begin checks++; failures++; $display("FAIL w_beats_timeout got=%0d want=%0d", w_cnt, target); end
    step();
  endtask
  task automatic send_b(input logic [1:0] resp);
    step();
    m_axi.bvalid = 1'b1; m_axi.bresp = resp;
    step();
    m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
  endtask
  task automatic test_reset();
    i_reset_n = 1'b0; m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00; m_axi.bid = '0;
    repeat (2) step();
    checks++; if (m_axi.awvalid !== 1'b0) begin failures++; $display("FAIL rst_awvalid got=%b want=0", m_axi.awvalid); end
    checks++; if (m_axi.wvalid !== 1'b0) begin failures++; $display("FAIL rst_wvalid got=%b want=0", m_axi.wvalid); end
    checks++; if (o_outst !== 4'd0) begin failures++; $display("FAIL rst_outst got=%0d want=0", o_outst); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", o_busy); end
    checks++; if (o_bresp_err_cnt !== 16'd0 || o_len_err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err_cnts got=%0d/%0d want=0/0", o_bresp_err_cnt, o_len_err_cnt); end
    i_reset_n = 1'b1;
    #1;
    checks++; if (m_axi.bready !== 1'b0) begin failures++; $display("FAIL bready_before_clk got=%b want=0", m_axi.bready); end
    step();
    checks++; if (m_axi.bready !== 1'b1) begin failures++; $display("FAIL bready_after_clk got=%b want=1", m_axi.bready); end
    checks++; if (m_axi.awsize !== 3'd5 || m_axi.awburst !== 2'b01) begin failures++; $display("FAIL aw_consts got=%0d/%b want=5/01", m_axi.awsize, m_axi.awburst); end
    checks++; if (m_axi.wstrb !== {(DW/8){1'b1}}) begin failures++; $display("FAIL wstrb got=%h want=all ones", m_axi.wstrb); end
    checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%b want=1", o_cmd_ready); end
  endtask
  task automatic test_single();
    logic [127:0] hdr = {2'b00, 2'b00, 4'h0, 120'h00112233445566778899AABBCCDDEE};
    logic [DW-1:0] exp0;
    logic [7:0] lp = '0;
    do_reset();
    send_cmd(64'h1000, 8'd3, hdr);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", o_busy); end
    send_payload(3, 16'h0008, 8'hAA);
    wait_w(4);
    exp0 = beat(8'hAA);
    exp0[127:0] = hdr;
    for (int k = 0; k < w_lasts.size() && k < 8; k++) lp[k] = w_lasts[k];
    checks++; if (aw_cnt !== 1 || aw_lens[0] !== 8'd3 || aw_addrs[0] !== 64'h1000 || aw_ids[0] !== 7'd0) begin failures++; $display("FAIL single_aw got cnt=%0d len=%0d addr=%h id=%0d want 1/3/1000/0", aw_cnt, aw_lens[0], aw_addrs[0], aw_ids[0]); end
    checks++; if (w_cnt !== 4) begin failures++; $display("FAIL single_wbeats got=%0d want=4", w_cnt); end
    checks++; if (w_data[0] !== exp0) begin failures++; $display("FAIL single_hdr_beat got=%h want=%h", w_data[0], exp0); end
    checks++; if (w_data[1] !== beat(8'hBB) || w_data[3] !== beat(8'hDD)) begin failures++; $display("FAIL single_payload got=%h/%h want BB../DD..", w_data[1], w_data[3]); end
    checks++; if (lp !== 8'b0000_1000) begin failures++; $display("FAIL single_wlast got=%b want=00001000", lp); end
    checks++; if (o_outst !== 4'd1) begin failures++; $display("FAIL single_outst1 got=%0d want=1", o_outst); end
    send_b(2'b00);
    checks++; if (o_outst !== 4'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL single_drain got outst=%0d busy=%b want 0/0", o_outst, o_busy); end
    checks++; if (o_bresp_err_cnt !== 16'd0 || o_len_err_cnt !== 16'd0) begin failures++; $display("FAIL single_errs got=%0d/%0d want=0/0", o_bresp_err_cnt, o_len_err_cnt); end
  endtask
  task automatic test_pipelined();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_cmd(64'h100, 8'd2, {2'(i), 2'b00, 4'h0, 120'(i + 1)});
      send_payload(2, 16'h0004, 8'h10 + 8'(i * 48));
    end
    wait_w(9);
    repeat (20) step();
    checks++; if (outst_peak !== 3 || o_outst !== 4'd3) begin failures++; $display("FAIL pipe_outst got peak=%0d now=%0d want 3/3", outst_peak, o_outst); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (aw_ids[i] !== 7'(i) || aw_addrs[i] !== 64'h100 || aw_lens[i] !== 8'd2) begin failures++; $display("FAIL pipe_aw%0d got id=%0d addr=%h len=%0d want %0d/100/2", i, aw_ids[i], aw_addrs[i], aw_lens[i], i); end
    end
    repeat (3) send_b(2'b00);
    checks++; if (o_outst !== 4'd0 || o_bresp_err_cnt !== 16'd0) begin failures++; $display("FAIL pipe_drain got outst=%0d berr=%0d want 0/0", o_outst, o_bresp_err_cnt); end
  endtask
  task automatic test_max_outst();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_cmd(64'h200 + 64'(i * 32), 8'd0, 128'(i));
      send_payload(0, 16'h0001, 8'h40 + 8'(i));
    end
    wait_w(4);
    checks++; if (o_outst !== 4'd4 || o_cmd_ready !== 1'b0) begin failures++; $display("FAIL max_full got outst=%0d rdy=%b want 4/0", o_outst, o_cmd_ready); end
    i_cmd_valid = 1'b1; i_cmd_addr = 64'h280; i_cmd_len = 8'd0; i_cmd_header = 128'h5;
    repeat (3) step();
    checks++; if (o_cmd_ready !== 1'b0 || m_axi.awvalid !== 1'b0) begin failures++; $display("FAIL max_blocked got rdy=%b awvalid=%b want 0/0", o_cmd_ready, m_axi.awvalid); end
    m_axi.bvalid = 1'b1;
    step();
    m_axi.bvalid = 1'b0;
    checks++; if (o_outst !== 4'd3 || o_cmd_ready !== 1'b1 || m_axi.awvalid !== 1'b0) begin failures++; $display("FAIL max_after_b got outst=%0d rdy=%b awvalid=%b want 3/1/0", o_outst, o_cmd_ready, m_axi.awvalid); end
    step();
    i_cmd_valid = 1'b0;
    checks++; if (m_axi.awvalid !== 1'b1 || m_axi.awaddr !== 64'h280) begin failures++; $display("FAIL max_fifth_aw got awvalid=%b addr=%h want 1/280", m_axi.awvalid, m_axi.awaddr); end
    send_payload(0, 16'h0001, 8'h50);
    wait_w(5);
    checks++; if (o_outst !== 4'd4 || o_cmd_ready !== 1'b0 || aw_cnt !== 5) begin failures++; $display("FAIL max_refull got outst=%0d rdy=%b aws=%0d want 4/0/5", o_outst, o_cmd_ready, aw_cnt); end
    send_b(2'b00);
    send_cmd(64'h2A0, 8'd0, 128'h6);
    send_payload(0, 16'h0001, 8'h60);
    wait_w(6);
    checks++; if (aw_cnt !== 6 || o_outst !== 4'd4 || aw_ids[5] !== 7'd5) begin failures++; $display("FAIL max_sixth got aws=%0d outst=%0d id=%0d want 6/4/5", aw_cnt, o_outst, aw_ids[5]); end
  endtask
  task automatic test_backpressure();
    logic [127:0] hdr = {2'b01, 2'b10, 4'h3, 120'hFEEDFACE};
    logic [DW-1:0] exp0;
    logic [7:0] lp = '0;
    int bad = 0;
    do_reset();
    done = 1'b0;
    fork
      begin
        send_cmd(64'h3000, 8'd7, hdr);
        send_payload(7, 16'h0080, 8'h01);
        wait_w(8);
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          m_axi.awready = 1'($urandom_range(0, 1));
          m_axi.wready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    exp0 = beat(8'h01);
    exp0[127:0] = hdr;
    for (int k = 0; k < w_lasts.size() && k < 8; k++) lp[k] = w_lasts[k];
    for (int k = 1; k < 8; k++) if (w_data[k] !== beat(bbyte(8'h01, k))) bad++;
    checks++; if (stab_viol !== 0) begin failures++; $display("FAIL bp_stable got=%0d violations want=0", stab_viol); end
    checks++; if (w_cnt !== 8 || aw_cnt !== 1 || aw_addrs[0] !== 64'h3000) begin failures++; $display("FAIL bp_counts got w=%0d aw=%0d addr=%h want 8/1/3000", w_cnt, aw_cnt, aw_addrs[0]); end
    checks++; if (w_data[0] !== exp0 || bad !== 0) begin failures++; $display("FAIL bp_order got bad=%0d beat0=%h want 0/%h", bad, w_data[0], exp0); end
    checks++; if (lp !== 8'h80) begin failures++; $display("FAIL bp_wlast got=%b want=10000000", lp); end
  endtask
  task automatic test_errors();
    logic [7:0] lp = '0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_cmd(64'h4000, 8'd0, 128'h1);
      send_payload(0, 16'h0001, 8'h20);
    end
    wait_w(2);
    send_b(2'b10);
    send_b(2'b10);
    checks++; if (o_bresp_err_cnt !== 16'd2 || o_outst !== 4'd0) begin failures++; $display("FAIL err_bresp got=%0d outst=%0d want 2/0", o_bresp_err_cnt, o_outst); end
    send_cmd(64'h4100, 8'd3, 128'h2);
    send_payload(3, 16'h000A, 8'h55);
    wait_w(6);
    for (int k = 2; k < w_lasts.size() && k < 10; k++) lp[k-2] = w_lasts[k];
    checks++; if (o_len_err_cnt !== 16'd1) begin failures++; $display("FAIL err_early_last got=%0d want=1", o_len_err_cnt); end
    checks++; if (w_cnt !== 6 || lp !== 8'b0000_1000) begin failures++; $display("FAIL err_burst_shape got w=%0d last=%b want 6/00001000", w_cnt, lp); end
    send_b(2'b00);
    send_cmd(64'h4200, 8'd1, 128'h3);
    send_payload(1, 16'h0000, 8'h66);
    wait_w(8);
    checks++; if (o_len_err_cnt !== 16'd2 || w_lasts[7] !== 1'b1 || w_cnt !== 8) begin failures++; $display("FAIL err_missing_last got cnt=%0d wlast=%b w=%0d want 2/1/8", o_len_err_cnt, w_lasts[7], w_cnt); end
    send_b(2'b00);
    checks++; if (o_outst !== 4'd0 || o_bresp_err_cnt !== 16'd2) begin failures++; $display("FAIL err_okay_b got outst=%0d berr=%0d want 0/2", o_outst, o_bresp_err_cnt); end
    send_b(2'b00);
    checks++; if (o_outst !== 4'd0 || o_bresp_err_cnt !== 16'd3) begin failures++; $display("FAIL err_spurious_b got outst=%0d berr=%0d want 0/3", o_outst, o_bresp_err_cnt); end
  endtask
  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    send_cmd(64'h5000, 8'd3, 128'h7);
    i_pl_valid = 1'b1; i_pl_data = beat(8'h77); i_pl_last = 1'b0;
    while (w_cnt < 3 && n < 100) begin @(negedge i_clk); n++; end
    checks++; if (n >= 100) begin failures++; $display("FAIL mid_reach_beat2 got w=%0d want=3", w_cnt); end
    #2;
    i_reset_n = 1'b0; i_pl_valid = 1'b0;
    #1;
    checks++; if (m_axi.wvalid !== 1'b0 || m_axi.awvalid !== 1'b0 || m_axi.bready !== 1'b0) begin failures++; $display("FAIL mid_valids got w=%b aw=%b bready=%b want 0/0/0", m_axi.wvalid, m_axi.awvalid, m_axi.bready); end
    checks++; if (o_outst !== 4'd0 || o_busy !== 1'b0 || o_pl_ready !== 1'b0) begin failures++; $display("FAIL mid_state got outst=%0d busy=%b plr=%b want 0/0/0", o_outst, o_busy, o_pl_ready); end
    repeat (2) step();
    i_reset_n = 1'b1;
    clear_mon();
    send_cmd(64'h6000, 8'd1, 128'h8);
    send_payload(1, 16'h0002, 8'h30);
    wait_w(2);
    checks++; if (aw_cnt !== 1 || aw_ids[0] !== 7'd0 || aw_addrs[0] !== 64'h6000) begin failures++; $display("FAIL mid_after_aw got aws=%0d id=%0d addr=%h want 1/0/6000", aw_cnt, aw_ids[0], aw_addrs[0]); end
    checks++; if (w_cnt !== 2 || w_data[1] !== beat(8'h41) || w_lasts[1] !== 1'b1) begin failures++; $display("FAIL mid_after_w got w=%0d last=%b data=%h want 2/1/41..", w_cnt, w_lasts[1], w_data[1]); end
    send_b(2'b00);
    checks++; if (o_outst !== 4'd0 || o_bresp_err_cnt !== 16'd0) begin failures++; $display("FAIL mid_after_b got outst=%0d berr=%0d want 0/0", o_outst, o_bresp_err_cnt); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_pipelined();
    test_max_outst();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_vdm_write_master.md
Name: axi_vdm_write_master

Overview:
Synthesisable, parametrised AXI4 write master that turns queued MCTP-over-PCIe VDM fragment commands (128-bit TLP header plus streamed payload) into AXI write bursts. The header is inserted into the low 128 bits of beat 0. Up to MAX_OUTST writes may await B responses, and response errors are counted. It sits between the fragment scheduler and the AXI interconnect, replacing the behavioural write generator in the assembly data path.

Parameters:
DATA_W, 256, AXI data width in bits; multiple of 128, at least 128
ADDR_W, 64, AXI address width
ID_W, 7, AXI ID width
MAX_OUTST, 4, maximum AW-issued writes without a B response (1..15)
ERR_CNT_W, 16, width of the saturating error counters

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset, asynchronous assert, active low
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when high together with i_cmd_valid
i_cmd_addr  in  ADDR_W  burst address
i_cmd_len  in  8  AXI len, beats-1
i_cmd_header  in  128  TLP header {pkt_type[1:0], sn[1:0], msg_t[3:0], hdr[119:0]}
i_pl_valid  in  1  payload beat valid
o_pl_ready  out  1  payload beat accepted
i_pl_data  in  DATA_W  payload beat; bits [127:0] are ignored on beat 0
i_pl_last  in  1  last payload beat marker
O_AWID/O_AWADDR/O_AWLEN/O_AWSIZE/O_AWBURST/O_AWVALID  out  ID_W/ADDR_W/8/3/2/1  AXI AW channel
I_AWREADY  in  1
O_WDATA/O_WSTRB/O_WLAST/O_WVALID  out  DATA_W/DATA_W/8/1/1  AXI W channel
I_WREADY  in  1
I_BID/I_BRESP/I_BVALID  in  ID_W/2/1  AXI B channel
O_BREADY  out  1
o_outst  out  4  current outstanding write count
o_bresp_err_cnt  out  ERR_CNT_W  count of B responses with BRESP != OKAY
o_len_err_cnt  out  ERR_CNT_W  count of i_pl_last / length mismatches
o_busy  out  1  FSM not IDLE, or o_outst != 0

Behaviour:
- Reset: every output register is 0. O_BREADY goes to 1 on the first clock after reset release. O_AWSIZE = log2(DATA_W/8) and O_AWBURST = 2'b01 (INCR) are constants. O_WSTRB is all ones.
- FSM has three states: IDLE, AW, W.
- IDLE: o_cmd_ready = (o_outst < MAX_OUTST). On handshake the block latches addr, len and header, loads the AW registers, sets O_AWVALID = 1 and moves to AW. Earliest AW is the cycle after acceptance.
- AW: O_AWVALID and all AW fields stay stable until I_AWREADY. On handshake: O_AWVALID = 0, the AWID counter increments (wrapping at 2^ID_W), o_outst increments, and the FSM moves to W.
- W: O_WDATA is a registered output stage. o_pl_ready = (!O_WVALID || I_WREADY). When a payload beat is accepted, O_WDATA loads it; on beat 0 the load is {i_pl_data[DATA_W-1:128], header}.
- W beat counting: O_WLAST = (beat == len). After the W handshake of the last beat: O_WVALID = 0 and the FSM returns to IDLE.
- Back-to-back: W beats with WVALID held continuously give 1 beat/cycle.
- B channel is independent of the FSM. On a B handshake o_outst decrements. If AW and B handshakes land in the same cycle, o_outst is unchanged.
- B when o_outst == 0: treated as spurious, ignored, o_bresp_err_cnt += 1.
- BRESP != 0: o_bresp_err_cnt increments and saturates at all-ones.
- Length mismatch:
  - i_pl_last high on a beat other than the last: o_len_err_cnt += 1 and the beat is still sent.
  - i_pl_last low on the last beat: the counter also increments.
  - The burst always ends on the AXI length.
- Reset mid-burst: FSM goes to IDLE, outstanding count and counters clear, VALIDs drop immediately. Any in-flight AXI transaction is abandoned.

Optional Feature:
Macro AXI_VDM_WR_TIMEOUT_EN.
- Defined: adds parameter TMO_CYC (default 1024) and output o_tmo (1 bit).
  - A counter runs while o_outst != 0 and no B handshake occurs; it clears on each B handshake.
  - On reaching TMO_CYC: o_tmo pulses for 1 cycle, o_outst is forced to 0 and o_bresp_err_cnt += 1.
- Undefined: no counter, no o_tmo port, no timeout recovery.

Test Plan:
1. Single fragment, header {S,SN0,MSG_T0,...}, len=3, I_AWREADY/I_WREADY tied 1, payload AAAA.., BBBB.., CCCC.., DDDD..
   -> one AW with AWLEN=3 and AWSIZE=5 (DATA_W=256); 4 W beats, WDATA[127:0]=header on beat 0, WLAST on beat 3; BRESP=0 gives o_outst 1->0 and error counters 0.
2. S/M/L three-command sequence, addr 0x100, len=2, B delayed 20 cycles
   -> three AWs issue without waiting; AWID = 0,1,2; o_outst peaks at 3 and drains to 0.
3. MAX_OUTST=4, B withheld, 6 commands offered
   -> o_cmd_ready low after the 4th AW; the 5th command is accepted the cycle after the first B handshake.
4. Random WREADY/AWREADY backpressure (50%), len=7
   -> O_WDATA/O_AWADDR stable while VALID && !READY; payload order is preserved; exactly 8 beats are sent.
5. Two B responses with BRESP=2, then i_pl_last asserted on beat 1 of a len=3 burst
   -> o_bresp_err_cnt=2, o_len_err_cnt=1; the burst still has 4 beats with WLAST on beat 3.
6. Reset asserted mid-W (beat 2 of 4)
   -> all VALIDs are 0 asynchronously and o_outst=0; after release a new command completes normally.
